// File: rtl/csa_nibble_sequencer.sv
// Two-requester 16-bit adder that reuses a single 4-bit carry-select slice over four cycles.
// Round-robin grant in IDLE, nibble-serial add in ADD, one-cycle completion pulse in DONE.
module csa_nibble_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [1:0]  cin,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [15:0] sum,
    output logic        cout
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state_reg;
    logic [15:0] op_a_reg;
    logic [15:0] op_b_reg;
    logic [11:0] part_reg;
    logic [1:0]  cnt_reg;
    logic        carry_reg;
    logic        last_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        done_id_reg;
    logic [15:0] sum_reg;
    logic        cout_reg;

    logic [1:0]  gnt_next;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic [3:0]  slice_sum;
    logic        slice_cout;

    // On a tie, serve whoever was not served last; a lone request always wins.
    always_comb begin
        gnt_next = 2'b00;
        if (reset_n && state_reg == IDLE) begin
            if (req == 2'b11)
                gnt_next = last_reg ? 2'b01 : 2'b10;
            else
                gnt_next = req;
        end
    end

    // Operands are shifted right each ADD cycle, so the active nibble is always [3:0].
    assign nib_a = op_a_reg[3:0];
    assign nib_b = op_b_reg[3:0];
    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign s0[gi]    = nib_a[gi] ^ nib_b[gi] ^ c0[gi];
            assign c0[gi+1]  = (nib_a[gi] & nib_b[gi]) | (c0[gi] & (nib_a[gi] ^ nib_b[gi]));
            assign s1[gi]    = nib_a[gi] ^ nib_b[gi] ^ c1[gi];
            assign c1[gi+1]  = (nib_a[gi] & nib_b[gi]) | (c1[gi] & (nib_a[gi] ^ nib_b[gi]));
        end
    endgenerate

    assign slice_sum  = carry_reg ? s1 : s0;
    assign slice_cout = carry_reg ? c1[4] : c0[4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            op_a_reg    <= 16'h0000;
            op_b_reg    <= 16'h0000;
            part_reg    <= 12'h000;
            cnt_reg     <= 2'd0;
            carry_reg   <= 1'b0;
            last_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            sum_reg     <= 16'h0000;
            cout_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (gnt_next != 2'b00) begin
                        state_reg <= ADD;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= 2'd0;
                        if (gnt_next[1]) begin
                            op_a_reg  <= a1;
                            op_b_reg  <= b1;
                            carry_reg <= cin[1];
                            last_reg  <= 1'b1;
                        end else begin
                            op_a_reg  <= a0;
                            op_b_reg  <= b0;
                            carry_reg <= cin[0];
                            last_reg  <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    op_a_reg  <= {4'h0, op_a_reg[15:4]};
                    op_b_reg  <= {4'h0, op_b_reg[15:4]};
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 2'd1;
                    // Lower nibbles accumulate privately; sum only changes on completion.
                    if (cnt_reg == 2'd3) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        sum_reg     <= {slice_sum, part_reg};
                        cout_reg    <= slice_cout;
                        done_id_reg <= last_reg;
                    end else begin
                        part_reg <= {slice_sum, part_reg[11:4]};
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_next;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign sum     = sum_reg;
    assign cout    = cout_reg;

endmodule

// File: tb/tb_csa_nibble_sequencer.sv
// Directed bench for csa_nibble_sequencer: hand-computed sums, grant order, latency and reset abort.
module tb_csa_nibble_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  cin;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [15:0] sum;
    logic        cout;

    int total = 0;
    int bad   = 0;
    logic [15:0] prev_sum;

    csa_nibble_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .cin     (cin),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = 2'b00;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        prev_sum = 16'h0000;
    endtask

    // One full transaction: request in an IDLE cycle, grant edge, four ADD edges, Done.
    task automatic do_op(input logic [1:0] r, input logic [15:0] xa0, input logic [15:0] xb0,
                         input logic [15:0] xa1, input logic [15:0] xb1, input logic [1:0] xc,
                         input logic [1:0] eg, input logic eid, input logic [15:0] es,
                         input logic ec, input bit hold);
        int cyc;
        bit seen;
        @(posedge clk);
        @(negedge clk);
        req = r; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; cin = xc;
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("grant", {30'd0, gnt}, {30'd0, eg});
        @(posedge clk);
        #1;
        // Captured operands must be immune to later input changes.
        a0 = ~xa0; b0 = ~xb0; a1 = ~xa1; b1 = ~xb1; cin = ~xc;
        if (!hold) req = 2'b00;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            cyc = i;
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("busy_add", {31'd0, busy}, 32'd1);
            check("gnt_busy", {30'd0, gnt}, 32'd0);
            check("sum_hold", {16'd0, sum}, {16'd0, prev_sum});
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_cycle", cyc, 32'd5);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_gnt", {30'd0, gnt}, 32'd0);
        check("sum", {16'd0, sum}, {16'd0, es});
        check("cout", {31'd0, cout}, {31'd0, ec});
        check("done_id", {31'd0, done_id}, {31'd0, eid});
        $display("op req=%b gnt=%b id=%0d sum=%h cout=%0d", r, eg, done_id, sum, cout);
        prev_sum = es;
    endtask

    initial begin
        reset_n = 1'b0;
        req = 2'b11;
        a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0; cin = 2'b00;
        prev_sum = 16'h0000;
        #12;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_id", {31'd0, done_id}, 32'd0);
        $display("reset state checked");
        req = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;

        do_op(2'b01, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 2'b00, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op(2'b01, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b01, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(2'b01, 16'h0F0F, 16'h00F1, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Tie after reset: requester 0 first, then alternate.
        do_reset();
        do_op(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 2'b00, 2'b01, 1'b0, 16'h0002, 1'b0, 1'b1);
        do_op(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 2'b00, 2'b10, 1'b1, 16'h0004, 1'b0, 1'b1);
        do_op(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 2'b00, 2'b01, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Abort during nibble 2 of 0x8888+0x8888.
        @(posedge clk);
        @(negedge clk);
        req = 2'b01; a0 = 16'h8888; b0 = 16'h8888; cin = 2'b00;
        #1;
        check("abort_gnt", {30'd0, gnt}, 32'd1);
        @(posedge clk);
        #1 req = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        $display("abort reset applied sum=%h busy=%0d", sum, busy);
        @(negedge clk);
        reset_n  = 1'b1;
        prev_sum = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        do_op(2'b01, 16'h8888, 16'h8888, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h1110, 1'b1, 1'b0);

        // Back-to-back with req held; Done every six cycles, sum steady between pulses.
        do_op(2'b01, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h3333, 1'b0, 1'b1);
        do_op(2'b01, 16'hA000, 16'h7000, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h1000, 1'b1, 1'b1);
        do_op(2'b01, 16'h00FF, 16'h0001, 16'h0000, 16'h0000, 2'b00, 2'b01, 1'b0, 16'h0100, 1'b0, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_nibble_sequencer.md
CSA_NIBBLE_SEQUENCER -- requirements
Module: csa_nibble_sequencer

Interface
REQ-001 Parameters: none; all widths fixed as below.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Req  input  2  add request per requester; bit i = requester i.
REQ-005 A0, B0  input  16 each  operands of requester 0.
REQ-006 A1, B1  input  16 each  operands of requester 1.
REQ-007 Cin  input  2  carry-in per requester; bit i belongs to requester i.
REQ-008 Gnt  output  2  one-hot grant, combinational; operands of the granted requester are captured on this edge.
REQ-009 Busy  output  1  high in ADD and DONE states.
REQ-010 Done  output  1  one-cycle pulse; Sum, Cout and DoneId are valid this cycle.
REQ-011 DoneId  output  1  requester index of the completed add.
REQ-012 Sum  output  16  result of the last completed add; holds until the next completion.
REQ-013 Cout  output  1  carry out of bit 15 of the last completed add; holds with Sum.

Function
REQ-014 Datapath SHALL be exactly one 4-bit carry-select adder slice, reused over four cycles; no wider adder.
REQ-015 FSM states SHALL be IDLE, ADD and DONE.
- IDLE->ADD when any Req bit is high.
- ADD->DONE after nibble counter reaches 3.
- DONE->IDLE unconditionally.
REQ-016 Gnt SHALL be nonzero only in IDLE with Req!=0; in ADD and DONE Gnt=0 and Req is ignored.
REQ-017 On the grant edge, the block SHALL register the granted A, B and Cin and the requester id.
- Nibble counter SHALL clear to 0.
- Carry register SHALL load the granted Cin.
REQ-018 Each ADD cycle n (0..3) SHALL:
- add nibble n of A and B plus the carry register;
- write the 4-bit slice sum to result bits [4n+3:4n];
- load the slice carry-out into the carry register;
- increment n.
REQ-019 Latency: with the grant edge as edge 0, ADD spans edges 1-4 and Done is high in the cycle after edge 4; the next grant is possible no earlier than the cycle after Done.
REQ-020 Sum, Cout and DoneId outputs SHALL update only on the ADD->DONE transition.
- Partial nibble results SHALL never appear on Sum.
REQ-021 Arbitration SHALL be round-robin using a last-served pointer:
- if both Req bits are high, grant the requester that was not last served;
- if only one Req bit is high, grant it regardless of the pointer.
REQ-022 The pointer SHALL update on each grant edge.
REQ-023 Arithmetic SHALL be unsigned modulo 2^16, with Cout carrying bit 16.
REQ-024 A requester dropping Req after its grant SHALL have no effect on the operation in progress.

Reset
REQ-025 While Reset_n=0, asynchronously:
- state=IDLE;
- counter=0, carry=0;
- Sum=0, Cout=0, DoneId=0;
- Busy=0, Done=0, Gnt=0;
- last-served pointer=1, so requester 0 wins the first tie.
REQ-026 Reset asserted mid-ADD or in DONE SHALL abort the operation.
- No Done pulse for the aborted add.
- Sum keeps its reset value of 0.
REQ-027 After Reset_n deassertion, the first grant SHALL occur no earlier than the first rising edge with Reset_n=1 and Req!=0.

Verification
REQ-028 Req=01, A0=0x1234, B0=0x4321, Cin=00 -> Gnt=01 in cycle 0; Done in cycle 5; Sum=0x5555, Cout=0, DoneId=0.
REQ-029 Req=10, A1=0xFFFF, B1=0x0001, Cin=00 -> Sum=0x0000, Cout=1, DoneId=1 (carry ripples through all four nibbles).
REQ-030 Req=01, A0=0xFFFF, B0=0x0000, Cin=01 -> Sum=0x0000, Cout=1; A0=0x0F0F, B0=0x00F1, Cin=00 -> Sum=0x1000, Cout=0.
REQ-031 Req=11 held after reset, requester 0 adds 1+1 and requester 1 adds 2+2 -> grants alternate 01,10,01; DoneId sequence 0,1,0; Sums 0x0002, 0x0004, 0x0002; Gnt=0 throughout every Busy period.
REQ-032 Reset_n pulsed low during ADD nibble 2 of 0x8888+0x8888 -> no Done; Sum=0, Busy=0 immediately; a following 0x8888+0x8888 request gives Sum=0x1110, Cout=1.
REQ-033 Req=01 held continuously -> back-to-back operations with Done every 6 cycles; Sum is stable between Done pulses.
